laser310_ram_seq: RTL

- Clocked bus sequencer for the Laser 310 64K expansion RAM. Replaces combinational strobe decoding.
- Synchronises Z80 bus strobes into the CPLD clock domain and latches the bank register from the I/O port write.
- Drives registered, glitch-free RAM_CS_N/RAM_OE_N/RAM_WE_N, with a programmable write-enable setup delay and a guaranteed recovery gap.
- Sits between the Z80 expansion edge connector and the 128K SRAM. Also drives the activity LEDs.

---
 rtl/laser310_ram_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/laser310_ram_seq.sv
// Laser 310 64K expansion RAM bus sequencer: synchronises Z80 strobes, holds the bank
// register and drives registered SRAM strobes with write-enable setup and recovery.
module laser310_ram_seq #(
  parameter logic [1:0]  BANK_RESET = 2'b01,
  parameter logic [3:0]  IO_PORT    = 4'b0111,
  parameter int unsigned WE_DLY     = 1,
  parameter int unsigned LED_W      = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] Addr,
  input  logic [3:0] AddrIO,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       MREQ_N,
  input  logic       IORQ_N,
  input  logic [1:0] D1D0,
  output logic [1:0] RAM_A1514,
  output logic       RAM_CS_N,
  output logic       RAM_OE_N,
  output logic       RAM_WE_N,
  output logic [1:0] BANK,
  output logic       led1,
  output logic       led2
);

  typedef enum logic [2:0] {
    StIdle, StRdAct, StWrSetup, StWrAct, StRecover, StIoWr
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, sync2_q;  // {IORQ_N, MREQ_N, RD_N, WR_N}
  logic [2:0]       dly_q, dly_d;
  logic [1:0]       bank_q, bank_d;
  logic [1:0]       page_q, page_d;
  logic             cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [LED_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  logic       s_wr, s_rd, s_mreq, s_iorq;
  logic       win, memrd, memwr, iowr;
  logic [1:0] page_sel;

  assign s_wr   = sync2_q[0];
  assign s_rd   = sync2_q[1];
  assign s_mreq = sync2_q[2];
  assign s_iorq = sync2_q[3];

  assign win   = (Addr >= 5'h17);
  assign memrd = !s_mreq && s_iorq && !s_rd && s_wr && win;
  assign memwr = !s_mreq && s_iorq && s_rd && !s_wr && win;
  assign iowr  = !s_iorq && s_mreq && !s_wr && s_rd && (AddrIO == IO_PORT);

  // Page 0 is reserved for the 17h window; bank 0 aliases to page 1.
  assign page_sel = (Addr == 5'h17) ? 2'b00 : ((bank_q == 2'b00) ? 2'b01 : bank_q);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    bank_d  = bank_q;
    page_d  = page_q;
    unique case (state_q)
      StIdle: begin
        if (memrd) begin
          state_d = StRdAct;
          page_d  = page_sel;
        end else if (memwr) begin
          state_d = StWrSetup;
          dly_d   = 3'(WE_DLY);
          page_d  = page_sel;
        end else if (iowr) begin
          state_d = StIoWr;
          bank_d  = D1D0;
        end
      end
      StRdAct: begin
        if (s_mreq || s_rd) state_d = StRecover;
      end
      StWrSetup: begin
        // An early strobe release aborts the write before any WE pulse.
        if (s_mreq || s_wr)     state_d = StRecover;
        else if (dly_q == 3'd0) state_d = StWrAct;
        else                    dly_d   = dly_q - 3'd1;
      end
      StWrAct: begin
        if (s_mreq || s_wr) state_d = StRecover;
      end
      StRecover: state_d = StIdle;
      StIoWr: begin
        if (s_iorq || s_wr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they register on the transition edge.
  always_comb begin
    cs_n_d = !((state_d == StRdAct) || (state_d == StWrSetup) || (state_d == StWrAct));
    oe_n_d = (state_d != StRdAct);
    we_n_d = (state_d != StWrAct);
  end

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if ((state_q == StIdle) && ((state_d == StRdAct) || (state_d == StWrSetup))) begin
      cnt1_d = '1;
    end else if (cnt1_q != '0) begin
      cnt1_d = cnt1_q - 1'b1;
    end
    if ((state_q != StWrAct) && (state_d == StWrAct)) begin
      cnt2_d = '1;
    end else if (cnt2_q != '0) begin
      cnt2_d = cnt2_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      state_q <= StIdle;
      dly_q   <= 3'd0;
      bank_q  <= BANK_RESET;
      page_q  <= 2'b00;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      sync1_q <= {IORQ_N, MREQ_N, RD_N, WR_N};
      sync2_q <= sync1_q;
      state_q <= state_d;
      dly_q   <= dly_d;
      bank_q  <= bank_d;
      page_q  <= page_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  assign RAM_A1514 = page_q;
  assign RAM_CS_N  = cs_n_q;
  assign RAM_OE_N  = oe_n_q;
  assign RAM_WE_N  = we_n_q;
  assign BANK      = bank_q;
  assign led1      = (cnt1_q != '0);
  assign led2      = (cnt2_q != '0);

endmodule
